ex_wb_regfile: RTL and testbench

Writeback end of the execute-stage result interface. It consumes the ALU result triple (rd, out_en, rd_data) and a valid/ready load-result stream from the LSU, and commits both into the 32-entry integer register file. It provides two combinational read ports to decode. When both writers want the single write port in the same cycle, the LSU result is held in a one-entry skid buffer.

---
 rtl/core_pkg.sv | 46 ++++
 rtl/wb_skid_buf.sv | 40 ++++
 rtl/ex_wb_regfile.sv | 127 ++++++++++++
 tb/tb_ex_wb_regfile.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared constants and types for the execute/writeback boundary.
//   XLEN     : register and result width
//   REG_NUM  : number of architectural integer registers
//   ADDR_W   : register index width
//   REG_ZERO : index of the hard-wired zero register
//   wb_req   : one writeback request {valid, rd, data}. The same type is used
//              for the ALU result, the LSU load result and the skid entry.
//   read_mux : read-port helper. It forces x0 to zero and optionally
//              forwards the value being written this cycle.
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req;

  // Returns the read-port value for one index.
  // A request with valid=0 disables forwarding, so the registered value is
  // returned unchanged.
  function automatic logic [XLEN-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [XLEN-1:0]   reg_val,
    input wb_req             fwd
  );
    logic [XLEN-1:0] result;
    result = reg_val;
    if (fwd.valid && (fwd.rd == addr)) begin
      result = fwd.data;
    end
    if (addr == REG_ZERO) begin
      result = '0;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// ---------------------------------------------------------------------------
// wb_skid_buf
// One-entry holding register for a load result. The entry waits here when
// the single register-file write port is taken by the ALU.
//   clk   : clock
//   rst   : synchronous active-low reset; empties the entry
//   push  : capture push_req this cycle (wins over pop/flush)
//   push_req : request to capture; only rd and data are stored
//   pop   : entry is committed to the register file this cycle
//   flush : a younger ALU write to the same rd makes the entry obsolete
//   entry : current contents; entry.valid means an uncommitted load result
// ---------------------------------------------------------------------------
module wb_skid_buf
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  wb_req push_req,
  input  logic  pop,
  input  logic  flush,
  output wb_req entry
);

  // A push in a pop cycle is the drain-and-refill case, so push wins.
  // An emptied entry is cleared to zero, which keeps pend_rd at 0 when the
  // buffer holds nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entry <= '0;
    end else if (push) begin
      entry.valid <= 1'b1;
      entry.rd    <= push_req.rd;
      entry.data  <= push_req.data;
    end else if (pop || flush) begin
      entry <= '0;
    end
  end

endmodule

// File: rtl/ex_wb_regfile.sv
// ---------------------------------------------------------------------------
// ex_wb_regfile
// Writeback end of the execute stage. ALU results and LSU load results are
// committed into the 32 x XLEN integer register file through one write port.
// Decode gets two combinational read ports.
//
// Optional build macro: WB_BYPASS_EN
//   defined   : a read port returns the value being written this cycle when
//               the index matches
//   undefined : a read port returns only the registered value
//
// Ports:
//   clk, rst              : clock; synchronous active-low reset
//   alu_rd/out_en/rd_data : ALU result. Always accepted.
//   lsu_valid/rd/data     : load result stream
//   lsu_ready             : load result can be accepted this cycle
//   rs1_addr/rs2_addr     : read indices
//   rs1_data/rs2_data     : read data (combinational)
//   pend_valid/pend_rd    : a buffered load result is outstanding, and its
//                           destination register
// ---------------------------------------------------------------------------
module ex_wb_regfile
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic              alu_out_en,
  input  logic [XLEN-1:0]   alu_rd_data,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_rd
);

  wb_req alu_req;
  wb_req lsu_req;
  wb_req pend;
  wb_req wr;
  wb_req fwd;

  logic lsu_xfer;
  logic drain;
  logic flush;
  logic direct;
  logic capture;

  logic [XLEN-1:0] regs [REG_NUM];

  assign alu_req.valid = alu_out_en;
  assign alu_req.rd    = alu_rd;
  assign alu_req.data  = alu_rd_data;

  assign lsu_req.valid = lsu_valid;
  assign lsu_req.rd    = lsu_rd;
  assign lsu_req.data  = lsu_data;

  // Write-port arbitration: ALU, then the buffered load, then a direct load.
  // An ALU write while the buffer is full blocks new loads, because the
  // buffer cannot drain that cycle. When the buffer drains, it can take a
  // new load in the same cycle.
  // A capture is dropped when it targets x0, or when it targets the same rd
  // as a simultaneous ALU write. In the same-rd case the ALU instruction is
  // younger, so the load value would be stale.
  always_comb begin
    lsu_ready = rst && !(pend.valid && alu_req.valid);
    lsu_xfer  = lsu_req.valid && lsu_ready;
    drain     = pend.valid && !alu_req.valid;
    flush     = alu_req.valid && pend.valid && (alu_req.rd == pend.rd);
    direct    = lsu_xfer && !alu_req.valid && !pend.valid;
    capture   = lsu_xfer && (alu_req.valid || pend.valid)
                && (lsu_req.rd != REG_ZERO)
                && !(alu_req.valid && (alu_req.rd == lsu_req.rd));

    wr = '0;
    if (alu_req.valid) begin
      wr = alu_req;
    end else if (drain) begin
      wr = pend;
    end else if (direct) begin
      wr = lsu_req;
    end
    if ((wr.rd == REG_ZERO) || !rst) begin
      wr.valid = 1'b0;
    end
  end

  wb_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (capture),
    .push_req (lsu_req),
    .pop      (drain),
    .flush    (flush),
    .entry    (pend)
  );

  assign pend_valid = pend.valid;
  assign pend_rd    = pend.rd;

  // Register array. x0 is never written because wr.valid is masked for rd 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (wr.valid) begin
      regs[wr.rd] <= wr.data;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd = wr;
`else
  assign fwd = '0;
`endif

  assign rs1_data = read_mux(rs1_addr, regs[rs1_addr], fwd);
  assign rs2_data = read_mux(rs2_addr, regs[rs2_addr], fwd);

endmodule

// File: tb/tb_ex_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_ex_wb_regfile
// Directed scoreboard bench for ex_wb_regfile. Each stimulus step queues the
// expected outputs for that cycle. A monitor pops the queue and compares on
// the falling edge. Build with WB_BYPASS_EN to match a bypass-enabled DUT.
// ---------------------------------------------------------------------------
module tb_ex_wb_regfile;
  import core_pkg::*;

  localparam int K_RS1   = 0;
  localparam int K_RS2   = 1;
  localparam int K_PENDV = 2;
  localparam int K_PENDR = 3;
  localparam int K_READY = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] alu_rd;
  logic              alu_out_en;
  logic [XLEN-1:0]   alu_rd_data;
  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              lsu_ready;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_rd;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  ex_wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .alu_rd      (alu_rd),
    .alu_out_en  (alu_out_en),
    .alu_rd_data (alu_rd_data),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .pend_valid  (pend_valid),
    .pend_rd     (pend_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compares one queued expectation against the live DUT outputs.
  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    case (e.kind)
      K_RS1:   act = rs1_data;
      K_RS2:   act = rs2_data;
      K_PENDV: act = {31'd0, pend_valid};
      K_PENDR: act = {27'd0, pend_rd};
      default: act = {31'd0, lsu_ready};
    endcase
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%08h expected 0x%08h",
               e.name, e.cyc, act, e.exp);
    end
  endtask

  // The monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      checkOutput(cur);
    end
  end

  // Queues an expectation for the cycle that is currently being driven.
  task automatic expectOutput(input int kind, input logic [31:0] exp,
                              input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(
    input logic              a_en,
    input logic [ADDR_W-1:0] a_rd,
    input logic [XLEN-1:0]   a_data,
    input logic              l_v,
    input logic [ADDR_W-1:0] l_rd,
    input logic [XLEN-1:0]   l_data,
    input logic [ADDR_W-1:0] r1,
    input logic [ADDR_W-1:0] r2
  );
    alu_out_en  = a_en;
    alu_rd      = a_rd;
    alu_rd_data = a_data;
    lsu_valid   = l_v;
    lsu_rd      = l_rd;
    lsu_data    = l_data;
    rs1_addr    = r1;
    rs2_addr    = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A same-cycle read returns the written value only when bypass is built in.
  function automatic logic [31:0] byp(input logic [31:0] written,
                                      input logic [31:0] old);
`ifdef WB_BYPASS_EN
    return written;
`else
    return old;
`endif
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;

    // Write some registers and park a load in the buffer, then reset again.
    applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 2, 32'h55, 1, 10, 32'h77, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    expectOutput(K_READY, 0, "ready_in_reset");
    step();
    step();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2);
    expectOutput(K_RS1, 0, "reset_x1");
    expectOutput(K_RS2, 0, "reset_x2");
    expectOutput(K_PENDV, 0, "reset_pend_valid");
    expectOutput(K_PENDR, 0, "reset_pend_rd");
    expectOutput(K_READY, 1, "ready_after_reset");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 10, 0);
    expectOutput(K_RS1, 0, "reset_x10");
    step();

    // ALU only, including a write to x0.
    applyStimulus(1, 5, 32'h1234_5678, 0, 0, 0, 5, 0);
    expectOutput(K_RS1, byp(32'h1234_5678, 0), "alu_x5_same_cycle");
    step();
    applyStimulus(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 5, 0);
    expectOutput(K_RS1, 32'h1234_5678, "alu_x5");
    expectOutput(K_RS2, 0, "x0_same_cycle");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
    expectOutput(K_RS2, 0, "x0_after_write");
    step();

    // Collision: ALU takes the port, the load waits in the buffer.
    applyStimulus(1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
    expectOutput(K_READY, 1, "collide_ready");
    expectOutput(K_PENDV, 0, "collide_pend_before");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);
    expectOutput(K_RS1, 32'hA, "collide_x3");
    expectOutput(K_RS2, byp(32'hB, 0), "collide_x4_drain");
    expectOutput(K_PENDV, 1, "collide_pend_valid");
    expectOutput(K_PENDR, 4, "collide_pend_rd");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);
    expectOutput(K_RS2, 32'hB, "collide_x4");
    expectOutput(K_PENDV, 0, "collide_pend_clear");
    step();

    // Backpressure: buffer holds rd 6 while the ALU writes for 3 cycles.
    applyStimulus(1, 11, 32'h1, 1, 6, 32'h66, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 12, 32'(i + 2), 1, 13, 32'h99, 6, 0);
      expectOutput(K_READY, 0, "bp_ready_low");
      expectOutput(K_PENDV, 1, "bp_pend_valid");
      expectOutput(K_PENDR, 6, "bp_pend_rd");
      expectOutput(K_RS1, 0, "bp_x6_unwritten");
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 13);
    expectOutput(K_READY, 1, "bp_ready_idle");
    expectOutput(K_RS1, byp(32'h66, 0), "bp_x6_drain");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 12);
    expectOutput(K_RS1, 32'h66, "bp_x6");
    expectOutput(K_RS2, 32'h4, "bp_x12_last");
    expectOutput(K_PENDV, 0, "bp_pend_clear");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 13, 0);
    expectOutput(K_RS1, 0, "bp_x13_never_accepted");
    step();

    // Same-rd override: the younger ALU write discards the buffered load.
    applyStimulus(1, 14, 32'h5, 1, 7, 32'h11, 0, 0);
    step();
    applyStimulus(1, 7, 32'h22, 0, 0, 0, 7, 0);
    expectOutput(K_PENDV, 1, "ovr_pend_valid");
    expectOutput(K_PENDR, 7, "ovr_pend_rd");
    expectOutput(K_READY, 0, "ovr_ready");
    expectOutput(K_RS1, byp(32'h22, 0), "ovr_x7_same_cycle");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
    expectOutput(K_RS1, 32'h22, "ovr_x7");
    expectOutput(K_PENDV, 0, "ovr_pend_clear");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
    expectOutput(K_RS1, 32'h22, "ovr_x7_stays");
    step();

    // Simultaneous ALU and load to the same rd: the load is dropped.
    applyStimulus(1, 15, 32'hAA, 1, 15, 32'hBB, 0, 0);
    expectOutput(K_READY, 1, "same_rd_ready");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 15, 0);
    expectOutput(K_RS1, 32'hAA, "same_rd_x15");
    expectOutput(K_PENDV, 0, "same_rd_not_buffered");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 15, 0);
    expectOutput(K_RS1, 32'hAA, "same_rd_x15_stays");
    step();

    // A load to x0 alongside an ALU write is accepted but never buffered.
    applyStimulus(1, 16, 32'h1, 1, 0, 32'hCC, 0, 0);
    expectOutput(K_READY, 1, "x0_load_ready");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    expectOutput(K_PENDV, 0, "x0_load_not_buffered");
    step();

    // Direct load write with the port free.
    applyStimulus(0, 0, 0, 1, 17, 32'h1717, 17, 0);
    expectOutput(K_RS1, byp(32'h1717, 0), "direct_x17_same_cycle");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 17, 0);
    expectOutput(K_RS1, 32'h1717, "direct_x17");
    expectOutput(K_PENDV, 0, "direct_no_pend");
    step();

    // Drain plus refill in the same cycle.
    applyStimulus(1, 18, 32'h18, 1, 8, 32'h88, 0, 0);
    step();
    applyStimulus(0, 0, 0, 1, 9, 32'h99, 8, 9);
    expectOutput(K_READY, 1, "refill_ready");
    expectOutput(K_PENDR, 8, "refill_pend_rd8");
    expectOutput(K_RS1, byp(32'h88, 0), "refill_x8_drain");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 8, 9);
    expectOutput(K_RS1, 32'h88, "refill_x8");
    expectOutput(K_PENDV, 1, "refill_pend_valid");
    expectOutput(K_PENDR, 9, "refill_pend_rd9");
    expectOutput(K_RS2, byp(32'h99, 0), "refill_x9_drain");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 18, 9);
    expectOutput(K_RS1, 32'h18, "refill_x18");
    expectOutput(K_RS2, 32'h99, "refill_x9");
    expectOutput(K_PENDV, 0, "refill_pend_clear");
    step();

    step();
    step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
